// File: rtl/board_line_clear.sv
// Settled-block playfield for the game-control handshake: merges locked pieces,
// collapses full rows on a remove request and reports overflow and line counts.
module board_line_clear #(
    parameter int ROWS     = 20,
    parameter int COLS     = 10,
    parameter int DIE_ROWS = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             renew2,
    input  logic [4:0]       piece_row,
    input  logic [3:0]       piece_col,
    input  logic [15:0]      piece_mask,
    input  logic             remove,
    output logic             remove_finish,
    output logic             die_true,
    output logic [2:0]       last_cleared,
    output logic [CNT_W-1:0] lines_total,
    output logic             busy,
    input  logic [4:0]       rd_row,
    output logic [COLS-1:0]  rd_data
);

    localparam int SW = COLS + 19;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SHIFT, S_DONE} state_t;

    state_t            r_state, w_state_next;
    logic [COLS-1:0]   r_board [ROWS];
    logic [COLS-1:0]   w_board_next [ROWS];
    logic [4:0]        r_row;
    logic [2:0]        r_pass;
    logic              r_armed;
    logic              r_die;
    logic [2:0]        r_last;
    logic [CNT_W-1:0]  r_total;
    logic [COLS-1:0]   r_rd_data;
    logic [SW-1:0]     w_wide [4];
    logic [COLS-1:0]   w_pc [4];
    logic [COLS-1:0]   w_land;
    logic              w_start;
    logic              w_row_full;
    logic              w_land_full;
    logic              w_die;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign w_start     = remove && r_armed && (r_state == S_IDLE);
    assign w_row_full  = &r_board[r_row];
    // Row that lands at r during a shift; the shift cycle also scans it.
    assign w_land      = (r_row == 5'd0) ? '0 : r_board[5'(r_row - 5'd1)];
    assign w_land_full = &w_land;

    // Each piece-mask row placed at its column; bits past COLS fall off.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            w_wide[r] = SW'(piece_mask[4*r +: 4]) << piece_col;
            w_pc[r]   = w_wide[r][COLS-1:0];
        end
    end

    always_comb begin
        for (int i = 0; i < ROWS; i++) w_board_next[i] = r_board[i];
        if (r_state == S_IDLE && renew2) begin
            for (int i = 0; i < ROWS; i++)
                for (int r = 0; r < 4; r++)
                    if ({1'b0, piece_row} + 6'(r) == 6'(i))
                        w_board_next[i] = w_board_next[i] | w_pc[r];
        end else if (r_state == S_SHIFT) begin
            for (int i = 1; i < ROWS; i++)
                if (i <= int'(r_row)) w_board_next[i] = r_board[i-1];
            w_board_next[0] = '0;
        end
    end

    always_comb begin
        w_die = 1'b0;
        for (int i = 0; i < DIE_ROWS; i++) w_die = w_die | (|w_board_next[i]);
    end

    // Shift and rescan of row r share one cycle, so each cleared row costs one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_SCAN;
            S_SCAN: begin
                if (w_row_full)           w_state_next = S_SHIFT;
                else if (r_row == 5'd0)   w_state_next = S_DONE;
            end
            S_SHIFT: begin
                if (w_land_full)          w_state_next = S_SHIFT;
                else if (r_row == 5'd0)   w_state_next = S_DONE;
                else                      w_state_next = S_SCAN;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= S_IDLE;
            for (int i = 0; i < ROWS; i++) r_board[i] <= '0;
            r_row     <= '0;
            r_pass    <= '0;
            r_armed   <= 1'b1;
            r_die     <= 1'b0;
            r_last    <= '0;
            r_total   <= '0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_state_next;
            for (int i = 0; i < ROWS; i++) r_board[i] <= w_board_next[i];
            r_rd_data <= (rd_row < 5'(ROWS)) ? w_board_next[rd_row] : '0;

            if (w_start)      r_armed <= 1'b0;
            else if (!remove) r_armed <= 1'b1;

            if (w_start)                     r_die <= 1'b0;
            else if (w_state_next == S_DONE) r_die <= w_die;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_pass <= '0;
                        r_row  <= 5'(ROWS - 1);
                    end
                end
                S_SCAN: begin
                    if (!w_row_full && r_row != 5'd0) r_row <= r_row - 5'd1;
                end
                S_SHIFT: begin
                    if (r_pass != 3'd7) r_pass <= r_pass + 3'd1;
                    if (!w_land_full && r_row != 5'd0) r_row <= r_row - 5'd1;
                end
                S_DONE: begin
                    r_last  <= r_pass;
                    r_total <= sat_add(r_total, r_pass);
                end
                default: ;
            endcase
        end
    end

    assign remove_finish = (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE);
    assign die_true      = r_die;
    assign last_cleared  = r_last;
    assign lines_total   = r_total;
    assign rd_data       = r_rd_data;

endmodule

// File: tb/tb_board_line_clear.sv
// Directed bench for board_line_clear: merges, clear passes, overflow flag and abort.
module tb_board_line_clear;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        renew2 = 1'b0;
    logic [4:0]  piece_row = '0;
    logic [3:0]  piece_col = '0;
    logic [15:0] piece_mask = '0;
    logic        remove = 1'b0;
    logic        remove_finish;
    logic        die_true;
    logic [2:0]  last_cleared;
    logic [15:0] lines_total;
    logic        busy;
    logic [4:0]  rd_row = '0;
    logic [9:0]  rd_data;

    int n_total = 0;
    int n_bad   = 0;

    board_line_clear dut (
        .clk          (clk),
        .clr          (clr),
        .renew2       (renew2),
        .piece_row    (piece_row),
        .piece_col    (piece_col),
        .piece_mask   (piece_mask),
        .remove       (remove),
        .remove_finish(remove_finish),
        .die_true     (die_true),
        .last_cleared (last_cleared),
        .lines_total  (lines_total),
        .busy         (busy),
        .rd_row       (rd_row),
        .rd_data      (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic merge(input logic [4:0] row, input logic [3:0] col, input logic [15:0] mask);
        @(negedge clk);
        piece_row  = row;
        piece_col  = col;
        piece_mask = mask;
        renew2     = 1'b1;
        @(negedge clk) renew2 = 1'b0;
    endtask

    task automatic read_row(input logic [4:0] row, output logic [9:0] d);
        @(negedge clk) rd_row = row;
        @(posedge clk);
        #1 d = rd_data;
    endtask

    // Holds remove through finish plus three cycles; cyc = edges from request to finish.
    task automatic run_remove(output int cyc, output int nfin, output logic die_fin,
                              output logic die_start);
        cyc = 0; nfin = 0; die_fin = 1'b0; die_start = 1'b1;
        @(negedge clk) remove = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) die_start = die_true;
            if (remove_finish) begin
                nfin++;
                if (cyc == 0) begin
                    cyc     = n;
                    die_fin = die_true;
                end
            end
            if (cyc != 0 && n >= cyc + 3) break;
        end
        @(negedge clk) remove = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int         cyc, nfin;
        logic       dfin, dstart;
        logic [9:0] d;

        do_reset();
        #1;
        check("rst_finish", 32'(remove_finish), 32'd0);
        check("rst_die",    32'(die_true),      32'd0);
        check("rst_last",   32'(last_cleared),  32'd0);
        check("rst_total",  32'(lines_total),   32'd0);
        check("rst_busy",   32'(busy),          32'd0);
        check("rst_rd",     32'(rd_data),       32'd0);

        // T1: empty board
        run_remove(cyc, nfin, dfin, dstart);
        check("t1_cyc",   32'(cyc),          32'd21);
        check("t1_nfin",  32'(nfin),         32'd1);
        check("t1_last",  32'(last_cleared), 32'd0);
        check("t1_die",   32'(dfin),         32'd0);
        check("t1_total", 32'(lines_total),  32'd0);

        // T2: single full bottom row
        merge(5'd19, 4'd0, 16'h000F);
        merge(5'd19, 4'd4, 16'h000F);
        merge(5'd19, 4'd8, 16'h0003);
        merge(5'd18, 4'd0, 16'h0005);
        read_row(5'd19, d);
        check("t2_row19_pre", 32'(d), 32'h3FF);
        run_remove(cyc, nfin, dfin, dstart);
        check("t2_cyc",   32'(cyc),          32'd22);
        check("t2_nfin",  32'(nfin),         32'd1);
        check("t2_last",  32'(last_cleared), 32'd1);
        check("t2_total", 32'(lines_total),  32'd1);
        read_row(5'd19, d);
        check("t2_row19", 32'(d), 32'h005);
        read_row(5'd18, d);
        check("t2_row18", 32'(d), 32'h000);

        // T3: four stacked full rows
        merge(5'd16, 4'd0, 16'hFFFF);
        merge(5'd16, 4'd4, 16'hFFFF);
        merge(5'd16, 4'd8, 16'hFFFF);
        merge(5'd15, 4'd0, 16'h0001);
        run_remove(cyc, nfin, dfin, dstart);
        check("t3_cyc",   32'(cyc),          32'd25);
        check("t3_last",  32'(last_cleared), 32'd4);
        check("t3_total", 32'(lines_total),  32'd5);
        check("t3_die",   32'(dfin),         32'd0);
        read_row(5'd19, d);
        check("t3_row19", 32'(d), 32'h001);
        read_row(5'd18, d);
        check("t3_row18", 32'(d), 32'h000);
        read_row(5'd16, d);
        check("t3_row16", 32'(d), 32'h000);
        read_row(5'd15, d);
        check("t3_row15", 32'(d), 32'h000);

        // T4: overflow in the top row
        merge(5'd0, 4'd3, 16'h000F);
        read_row(5'd0, d);
        check("t4_row0", 32'(d), 32'h078);
        run_remove(cyc, nfin, dfin, dstart);
        check("t4_cyc",      32'(cyc),          32'd21);
        check("t4_die_fin",  32'(dfin),         32'd1);
        check("t4_last",     32'(last_cleared), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_die_hold", 32'(die_true), 32'd1);
        run_remove(cyc, nfin, dfin, dstart);
        check("t4_die_start", 32'(dstart), 32'd0);
        check("t4_die_fin2",  32'(dfin),   32'd1);

        // T5: clipping at right and bottom edges, out-of-range read
        merge(5'd5, 4'd8, 16'h000F);
        read_row(5'd5, d);
        check("t5_row5", 32'(d), 32'h300);
        merge(5'd18, 4'd0, 16'hFFFF);
        read_row(5'd19, d);
        check("t5_row19", 32'(d), 32'h00F);
        read_row(5'd18, d);
        check("t5_row18", 32'(d), 32'h00F);
        read_row(5'd20, d);
        check("t5_rd_oor", 32'(d), 32'h000);

        // T6: clr during a shift aborts the pass
        do_reset();
        merge(5'd19, 4'd0, 16'h000F);
        merge(5'd19, 4'd4, 16'h000F);
        merge(5'd19, 4'd8, 16'h0003);
        @(negedge clk) remove = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t6_busy_pre", 32'(busy), 32'd1);
        clr    = 1'b1;
        remove = 1'b0;
        #1;
        check("t6_busy",   32'(busy),          32'd0);
        check("t6_finish", 32'(remove_finish), 32'd0);
        check("t6_rd",     32'(rd_data),       32'd0);
        @(negedge clk) clr = 1'b0;
        nfin = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            #1;
            if (remove_finish) nfin++;
        end
        check("t6_no_finish", 32'(nfin), 32'd0);
        read_row(5'd19, d);
        check("t6_row19", 32'(d), 32'h000);
        run_remove(cyc, nfin, dfin, dstart);
        check("t6_cyc",  32'(cyc),          32'd21);
        check("t6_nfin", 32'(nfin),         32'd1);
        check("t6_last", 32'(last_cleared), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
